// File: rtl/param_led_chaser_if.sv
// Bundle of the chaser's control inputs and pattern outputs.
// The master side drives mode/pause/maximum; the slave side is the chaser itself.
interface param_led_chaser_if #(
    parameter int N_LED = 4,
    parameter int CNT_W = 8
);
    logic [1:0]       mode;
    logic             pause;
    logic [CNT_W-1:0] maximum;
    logic [N_LED-1:0] LED;
    logic             step;
    logic             dir;

    modport master (
        output mode,
        output pause,
        output maximum,
        input  LED,
        input  step,
        input  dir
    );

    modport slave (
        input  mode,
        input  pause,
        input  maximum,
        output LED,
        output step,
        output dir
    );
endinterface

// File: rtl/param_led_chaser.sv
// Prescaled LED pattern generator (rotate left/right, bounce, fill) driven by an
// IDLE/RUN/HOLD FSM; LED, dir and step are all registered.
module param_led_chaser #(
    parameter int N_LED = 4,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    param_led_chaser_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [1:0] MODE_ROT_L  = 2'b00;
    localparam logic [1:0] MODE_ROT_R  = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;
    localparam logic [1:0] MODE_FILL   = 2'b11;

    localparam logic [N_LED-1:0] LED_ZERO = {N_LED{1'b0}};
    localparam logic [N_LED-1:0] LED_ONES = {N_LED{1'b1}};
    localparam logic [N_LED-1:0] LED_LSB  = {{(N_LED-1){1'b0}}, 1'b1};
    localparam logic [N_LED-1:0] LED_MSB  = {1'b1, {(N_LED-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_LED-1:0] led_q, led_d;
    logic             dir_q, dir_d;
    logic             step_q, step_d;

    logic [N_LED-1:0] adv_led_s;
    logic             adv_dir_s;

    function automatic logic is_onehot(input logic [N_LED-1:0] v);
        return (v != LED_ZERO) && ((v & (v - LED_LSB)) == LED_ZERO);
    endfunction

    // Thermometer codes (0 or 2^k-1) are exactly the values where v+1 shares no bit with v.
    function automatic logic is_thermo(input logic [N_LED-1:0] v);
        return (v & (v + LED_LSB)) == LED_ZERO;
    endfunction

    // Pattern value and direction that the next advance would produce.
    always_comb begin
        adv_led_s = LED_LSB;
        adv_dir_s = 1'b0;
        case (bus.mode)
            MODE_ROT_L: begin
                if (is_onehot(led_q)) begin
                    adv_led_s = {led_q[N_LED-2:0], led_q[N_LED-1]};
                end else begin
                    adv_led_s = LED_LSB;
                end
                adv_dir_s = 1'b0;
            end
            MODE_ROT_R: begin
                if (is_onehot(led_q)) begin
                    adv_led_s = {led_q[0], led_q[N_LED-1:1]};
                end else begin
                    adv_led_s = LED_MSB;
                end
                adv_dir_s = 1'b1;
            end
            MODE_BOUNCE: begin
                if (!is_onehot(led_q)) begin
                    adv_led_s = LED_LSB;
                    adv_dir_s = 1'b0;
                end else if (!dir_q) begin
                    if (led_q[N_LED-1]) begin
                        adv_led_s = {1'b0, led_q[N_LED-1:1]};
                        adv_dir_s = 1'b1;
                    end else begin
                        adv_led_s = {led_q[N_LED-2:0], 1'b0};
                        adv_dir_s = 1'b0;
                    end
                end else begin
                    if (led_q[0]) begin
                        adv_led_s = {led_q[N_LED-2:0], 1'b0};
                        adv_dir_s = 1'b0;
                    end else begin
                        adv_led_s = {1'b0, led_q[N_LED-1:1]};
                        adv_dir_s = 1'b1;
                    end
                end
            end
            MODE_FILL: begin
                if (!is_thermo(led_q)) begin
                    adv_led_s = LED_LSB;
                end else if (led_q == LED_ONES) begin
                    adv_led_s = LED_ZERO;
                end else begin
                    adv_led_s = {led_q[N_LED-2:0], 1'b1};
                end
                adv_dir_s = 1'b0;
            end
            default: begin
                adv_led_s = LED_LSB;
                adv_dir_s = 1'b0;
            end
        endcase
    end

    // FSM next state, prescaler and pattern update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        led_d   = led_q;
        dir_d   = dir_q;
        step_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.pause) begin
                    state_d = HOLD;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // Compare with >= so a maximum lowered below cnt advances at once instead of wrapping.
                if (cnt_q >= bus.maximum) begin
                    cnt_d  = CNT_ZERO;
                    led_d  = adv_led_s;
                    dir_d  = adv_dir_s;
                    step_d = 1'b1;
                end else begin
                    cnt_d  = cnt_q + CNT_ONE;
                end
                if (bus.pause) begin
                    state_d = HOLD;
                end else begin
                    state_d = RUN;
                end
            end
            HOLD: begin
                if (bus.pause) begin
                    state_d = HOLD;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = CNT_ZERO;
                led_d   = LED_ZERO;
                dir_d   = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= CNT_ZERO;
            led_q   <= LED_ZERO;
            dir_q   <= 1'b0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            led_q   <= led_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
        end
    end

    assign bus.LED  = led_q;
    assign bus.dir  = dir_q;
    assign bus.step = step_q;

endmodule

// File: tb/tb_param_led_chaser.sv
// Self-checking bench: directed scenarios plus randomized traffic, compared every
// cycle against a behavioural model built on lit-bit positions and fill counts.
module tb_param_led_chaser;

    localparam int N = 4;
    localparam int W = 8;

    logic clk;
    logic rst;

    param_led_chaser_if #(.N_LED(N), .CNT_W(W)) bus ();

    param_led_chaser #(.N_LED(N), .CNT_W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Model: phase 0 = idle, 1 = running, 2 = held
    int           m_phase = 0;
    int           m_cnt   = 0;
    logic [N-1:0] m_led   = '0;
    logic         m_dir   = 1'b0;
    logic         m_step  = 1'b0;

    logic [N-1:0] st_led[$];
    logic         st_dir[$];
    int           st_t[$];

    logic [3:0] exp_rotl   [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] exp_bounce [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
    logic       exp_bdir   [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [3:0] exp_fill   [6] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b0000, 4'b0001};

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [N-1:0] bit_at(input int p);
        logic [N-1:0] v;
        v = '0;
        v[p] = 1'b1;
        return v;
    endfunction

    function automatic logic [N-1:0] low_ones(input int k);
        logic [N-1:0] v;
        v = '0;
        for (int i = 0; i < k; i++) v[i] = 1'b1;
        return v;
    endfunction

    task automatic model_advance();
        int ones;
        int p;
        ones = 0;
        p = 0;
        for (int i = 0; i < N; i++) begin
            if (m_led[i]) begin
                ones++;
                p = i;
            end
        end
        case (bus.mode)
            2'b00: begin
                p = (ones == 1) ? (p + 1) % N : 0;
                m_led = bit_at(p);
                m_dir = 1'b0;
            end
            2'b01: begin
                p = (ones == 1) ? (p + N - 1) % N : N - 1;
                m_led = bit_at(p);
                m_dir = 1'b1;
            end
            2'b10: begin
                if (ones != 1) begin
                    p = 0;
                    m_dir = 1'b0;
                end else if (m_dir == 1'b0) begin
                    if (p == N - 1) begin p = N - 2; m_dir = 1'b1; end
                    else p = p + 1;
                end else begin
                    if (p == 0) begin p = 1; m_dir = 1'b0; end
                    else p = p - 1;
                end
                m_led = bit_at(p);
            end
            default: begin
                if (m_led != low_ones(ones)) m_led = low_ones(1);
                else if (ones == N)          m_led = '0;
                else                         m_led = low_ones(ones + 1);
                m_dir = 1'b0;
            end
        endcase
    endtask

    task automatic model_edge();
        if (rst) begin
            m_phase = 0;
            m_cnt   = 0;
            m_led   = '0;
            m_dir   = 1'b0;
            m_step  = 1'b0;
        end else begin
            m_step = 1'b0;
            if (m_phase == 1) begin
                if (m_cnt >= int'(bus.maximum)) begin
                    m_cnt = 0;
                    model_advance();
                    m_step = 1'b1;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end
            m_phase = bus.pause ? 2 : 1;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc++;
        check_eq("led", 32'(bus.LED), 32'(m_led));
        check_eq("dir", 32'(bus.dir), 32'(m_dir));
        check_eq("step", 32'(bus.step), 32'(m_step));
        if (bus.step === 1'b1) begin
            st_led.push_back(bus.LED);
            st_dir.push_back(bus.dir);
            st_t.push_back(cyc);
        end
    endtask

    task automatic do_reset(input logic [1:0] md, input logic [W-1:0] mx);
        rst = 1'b1;
        bus.pause = 1'b0;
        bus.mode = md;
        bus.maximum = mx;
        cycle();
        cycle();
        check_eq("rst_led", 32'(bus.LED), 32'd0);
        check_eq("rst_step", 32'(bus.step), 32'd0);
        check_eq("rst_dir", 32'(bus.dir), 32'd0);
        st_led.delete();
        st_dir.delete();
        st_t.delete();
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   t_rel;
        logic found;
        int   pause_left;

        rst = 1'b1;
        bus.mode = 2'b00;
        bus.pause = 1'b0;
        bus.maximum = 8'd3;

        // ROT_L, maximum=3
        do_reset(2'b00, 8'd3);
        t_rel = cyc;
        repeat (21) cycle();
        check_eq("rotl_nsteps", 32'(st_t.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            if (i < st_led.size()) check_eq("rotl_led", 32'(st_led[i]), 32'(exp_rotl[i]));
        if (st_t.size() > 0) check_eq("rotl_first", 32'(st_t[0] - t_rel), 32'd5);
        for (int i = 1; i < st_t.size(); i++) check_eq("rotl_gap", 32'(st_t[i] - st_t[i-1]), 32'd4);

        // BOUNCE, maximum=0
        do_reset(2'b10, 8'd0);
        repeat (9) cycle();
        check_eq("bounce_nsteps", 32'(st_t.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < st_led.size()) begin
                check_eq("bounce_led", 32'(st_led[i]), 32'(exp_bounce[i]));
                check_eq("bounce_dir", 32'(st_dir[i]), 32'(exp_bdir[i]));
            end
        end

        // FILL, maximum=0
        do_reset(2'b11, 8'd0);
        repeat (7) cycle();
        check_eq("fill_nsteps", 32'(st_t.size()), 32'd6);
        for (int i = 0; i < 6; i++)
            if (i < st_led.size()) check_eq("fill_led", 32'(st_led[i]), 32'(exp_fill[i]));

        // Pause for 23 cycles mid-period, maximum=9
        do_reset(2'b00, 8'd9);
        repeat (11) cycle();
        repeat (3) cycle();
        bus.pause = 1'b1;
        repeat (23) cycle();
        bus.pause = 1'b0;
        repeat (20) cycle();
        check_eq("pause_nsteps", 32'(st_t.size() >= 2), 32'd1);
        if (st_t.size() >= 2) check_eq("pause_gap", 32'(st_t[1] - st_t[0]), 32'd33);

        // Mode change FILL -> ROT_R -> BOUNCE
        do_reset(2'b11, 8'd0);
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            cycle();
            if (bus.LED == 4'b0111) found = 1'b1;
        end
        check_eq("fill_reach_0111", 32'(found), 32'd1);
        bus.mode = 2'b01;
        cycle();
        check_eq("fill2rotr_led", 32'(bus.LED), 32'b1000);
        check_eq("fill2rotr_dir", 32'(bus.dir), 32'd1);
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            cycle();
            if (bus.LED == 4'b0010) found = 1'b1;
        end
        check_eq("rotr_reach_0010", 32'(found), 32'd1);
        bus.mode = 2'b10;
        cycle();
        check_eq("rotr2bounce_led", 32'(bus.LED), 32'b0001);
        check_eq("rotr2bounce_dir", 32'(bus.dir), 32'd1);
        cycle();
        check_eq("bounce_turn_led", 32'(bus.LED), 32'b0010);
        check_eq("bounce_turn_dir", 32'(bus.dir), 32'd0);

        // Drop maximum 100 -> 10 at cnt=50, then reset mid-run
        do_reset(2'b00, 8'd100);
        repeat (51) cycle();
        bus.maximum = 8'd10;
        cycle();
        check_eq("dropmax_step", 32'(bus.step), 32'd1);
        repeat (11) cycle();
        check_eq("dropmax_nsteps", 32'(st_t.size()), 32'd2);
        if (st_t.size() >= 2) check_eq("dropmax_gap", 32'(st_t[1] - st_t[0]), 32'd11);
        repeat (5) cycle();
        rst = 1'b1;
        bus.pause = 1'b1;
        cycle();
        check_eq("midrun_rst_led", 32'(bus.LED), 32'd0);
        check_eq("midrun_rst_step", 32'(bus.step), 32'd0);
        rst = 1'b0;
        bus.pause = 1'b0;

        // Randomized traffic
        pause_left = 0;
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 249) == 0);
            if (pause_left > 0) begin
                pause_left--;
                bus.pause = 1'b1;
            end else if ($urandom_range(0, 29) == 0) begin
                pause_left = $urandom_range(0, 25);
                bus.pause = 1'b1;
            end else begin
                bus.pause = 1'b0;
            end
            if ($urandom_range(0, 7) == 0) bus.mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0)
                bus.maximum = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 40))
                                                          : 8'($urandom_range(0, 4));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
